// File: rtl/fht_but_pipe.sv
// Two-stage radix-2 Hartley butterfly: Y0/Y1 = X0 +/- (X1*cos + X2*sin), round-half-up, optional /2.
// Build option FHT_BUT_SAT_EN: clamp overflowing outputs instead of wrapping them.
module fht_but_rnd #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12,
  parameter int VW    = D_BIT + W_BIT + 2
) (
  input  logic signed [VW-1:0]    v,
  input  logic                    scale,
  output logic signed [D_BIT-1:0] y,
  output logic                    ovf
);
  localparam logic signed [VW-1:0] HALF_LO = VW'(1) <<< (W_BIT-3);
  localparam logic signed [VW-1:0] HALF_HI = VW'(1) <<< (W_BIT-2);
  localparam logic signed [VW-1:0] YMAX    = (VW'(1) <<< (D_BIT-1)) - VW'(1);
  localparam logic signed [VW-1:0] YMIN    = ~YMAX;

  logic signed [VW-1:0] r_lo, r_hi, r;
  logic                 hi, lo;

  assign r_lo = (v + HALF_LO) >>> (W_BIT-2);
  assign r_hi = (v + HALF_HI) >>> (W_BIT-1);
  assign r    = scale ? r_hi : r_lo;
  assign hi   = r > YMAX;
  assign lo   = r < YMIN;
  assign ovf  = hi | lo;

`ifdef FHT_BUT_SAT_EN
  assign y = hi ? YMAX[D_BIT-1:0] : lo ? YMIN[D_BIT-1:0] : r[D_BIT-1:0];
`else
  assign y = r[D_BIT-1:0];
`endif
endmodule

module fht_but_pipe #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iCE,
  input  logic                    iVALID,
  input  logic                    iSEL,
  input  logic                    iSCALE,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  input  logic                    iCLR_OVF,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1,
  output logic                    oVALID,
  output logic                    oOVF
);
  localparam int PW     = D_BIT + W_BIT + 1;
  localparam int VW     = D_BIT + W_BIT + 2;
  localparam int STAGES = 2;

  logic signed [PW-1:0]       x1e, x2e, cse, sne, p_nxt, p_r;
  logic signed [D_BIT-1:0]    x0_r;
  logic                       scale_r;
  logic [STAGES-1:0]          vld_pipe;
  logic signed [VW-1:0]       e, pe;
  logic [1:0][VW-1:0]         v2;
  logic [1:0][D_BIT-1:0]      y2;
  logic [1:0]                 ovf2;

  assign x1e = {{(PW-D_BIT){iX_1[D_BIT-1]}}, iX_1};
  assign x2e = {{(PW-D_BIT){iX_2[D_BIT-1]}}, iX_2};
  assign cse = {{(PW-W_BIT){iCOS[W_BIT-1]}}, iCOS};
  assign sne = {{(PW-W_BIT){iSIN[W_BIT-1]}}, iSIN};

  // Bypass scales X1 to the same fixed-point weight as a twiddle product.
  assign p_nxt = iSEL ? (x1e <<< (W_BIT-2)) : (x1e * cse + x2e * sne);

  assign e  = {{(VW-D_BIT){x0_r[D_BIT-1]}}, x0_r} <<< (W_BIT-2);
  assign pe = {p_r[PW-1], p_r};
  assign v2[0] = e + pe;
  assign v2[1] = e - pe;

  for (genvar i = 0; i < 2; i++) begin : g_out
    fht_but_rnd #(.D_BIT(D_BIT), .W_BIT(W_BIT), .VW(VW)) u_rnd (
      .v     ($signed(v2[i])),
      .scale (scale_r),
      .y     (y2[i]),
      .ovf   (ovf2[i])
    );
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      p_r      <= '0;
      x0_r     <= '0;
      scale_r  <= 1'b0;
      vld_pipe <= '0;
      oY_0     <= '0;
      oY_1     <= '0;
      oOVF     <= 1'b0;
    end else if (iCE) begin
      p_r      <= p_nxt;
      x0_r     <= iX_0;
      scale_r  <= iSCALE;
      vld_pipe <= {vld_pipe[0], iVALID};
      oY_0     <= y2[0];
      oY_1     <= y2[1];
      // Set beats clear when both land in the same cycle.
      if (vld_pipe[0] && |ovf2) oOVF <= 1'b1;
      else if (iCLR_OVF)        oOVF <= 1'b0;
    end
  end

  assign oVALID = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_fht_but_pipe.sv
// Directed bench for fht_but_pipe (D_BIT=17, W_BIT=12): vector table plus overflow, enable and reset sequences.
module tb_fht_but_pipe;
  logic               iCLK = 1'b0, iRESET = 1'b0, iCE = 1'b1, iVALID = 1'b0;
  logic               iSEL = 1'b0, iSCALE = 1'b0, iCLR_OVF = 1'b0;
  logic signed [16:0] iX_0 = '0, iX_1 = '0, iX_2 = '0;
  logic signed [11:0] iSIN = '0, iCOS = '0;
  logic signed [16:0] oY_0, oY_1;
  logic               oVALID, oOVF;

  fht_but_pipe #(.D_BIT(17), .W_BIT(12)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iCE(iCE), .iVALID(iVALID), .iSEL(iSEL),
    .iSCALE(iSCALE), .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iSIN(iSIN),
    .iCOS(iCOS), .iCLR_OVF(iCLR_OVF), .oY_0(oY_0), .oY_1(oY_1),
    .oVALID(oVALID), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic sel, scale;
    int   x0, x1, x2, cs, sn;
    int   y0, y1;
    logic ovf;
  } vec_t;

  localparam int NV = 11;
  vec_t v[NV];
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input vec_t t);
    iSEL = t.sel; iSCALE = t.scale;
    iX_0 = 17'(t.x0); iX_1 = 17'(t.x1); iX_2 = 17'(t.x2);
    iCOS = 12'(t.cs); iSIN = 12'(t.sn);
  endtask

  initial begin
    int ov_y0, ovn_y0, idx, got;
    logic signed [16:0] p0, p1;
    logic pv;
`ifdef FHT_BUT_SAT_EN
    ov_y0 = 65535; ovn_y0 = -65536;
`else
    ov_y0 = -2;    ovn_y0 = 0;
`endif
    //        sel  sc    x0      x1     x2   cos   sin    y0     y1   ovf
    v[0]  = '{1'b0, 1'b0, 1000,   500,   0,   1024, 0,    1500,  500, 1'b0};
    v[1]  = '{1'b0, 1'b1, 1000,   500,   0,   1024, 0,    750,   250, 1'b0};
    v[2]  = '{1'b0, 1'b0, 0,      100,   200, 0,    1024, 200,  -200, 1'b0};
    v[3]  = '{1'b1, 1'b0, 10,     300,   0,   0,    0,    310,  -290, 1'b0};
    v[4]  = '{1'b0, 1'b1, 1,      0,     0,   1024, 0,    1,     1,   1'b0};
    v[5]  = '{1'b0, 1'b1, -1,     0,     0,   1024, 0,    0,     0,   1'b0};
    v[6]  = '{1'b0, 1'b1, -3,     0,     0,   1024, 0,   -1,    -1,   1'b0};
    v[7]  = '{1'b0, 1'b0, 65535,  65535, 0,   1024, 0,    ov_y0, 0,   1'b1};
    v[8]  = '{1'b0, 1'b0, -65536, -65536,0,   1024, 0,    ovn_y0,0,   1'b1};
    v[9]  = '{1'b0, 1'b0, 0,      512,   0,   1,    0,    1,     0,   1'b0};
    v[10] = '{1'b0, 1'b0, 0,      100,   0,  -1024, 0,   -100,   100, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_y0", oY_0, 0); chk("rst_y1", oY_1, 0);
    chk("rst_vld", oVALID, 0); chk("rst_ovf", oOVF, 0);
    iRESET = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(v[i]); iVALID = 1'b1; tick();
      iVALID = 1'b0; tick();
      chk($sformatf("v%0d_y0", i), oY_0, v[i].y0);
      chk($sformatf("v%0d_y1", i), oY_1, v[i].y1);
      chk($sformatf("v%0d_vld", i), oVALID, 1);
      chk($sformatf("v%0d_ovf", i), oOVF, v[i].ovf);
      iCLR_OVF = 1'b1; tick(); iCLR_OVF = 1'b0;
      chk($sformatf("v%0d_vld_drop", i), oVALID, 0);
      chk($sformatf("v%0d_ovf_clr", i), oOVF, 0);
    end

    // Overflow flag corner cases
    drive(v[7]); iVALID = 1'b0; tick(); tick();
    chk("ovf_nonvalid", oOVF, 0);
    iVALID = 1'b1; tick(); iVALID = 1'b0; tick();
    chk("ovf_set", oOVF, 1);
    iVALID = 1'b1; tick(); iVALID = 1'b0; iCLR_OVF = 1'b1; tick();
    chk("ovf_set_wins", oOVF, 1);
    iCE = 1'b0; tick();
    chk("ovf_clr_ce0", oOVF, 1);
    iCE = 1'b1; tick(); iCLR_OVF = 1'b0;
    chk("ovf_clr", oOVF, 0);

    // Streaming with gated enable: beat k gives Y0=11k, Y1=9k
    tick(); tick();
    idx = 0; got = 0;
    iSEL = 1'b0; iSCALE = 1'b0; iX_2 = '0; iCOS = 12'sd1024; iSIN = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      iCE = (c % 3 != 1);
      iVALID = (idx < 8);
      iX_0 = 17'((idx + 1) * 10);
      iX_1 = 17'(idx + 1);
      p0 = oY_0; p1 = oY_1; pv = oVALID;
      tick();
      if (iCE) begin
        if (iVALID) idx++;
        if (oVALID) begin
          chk($sformatf("str%0d_y0", got), oY_0, (got + 1) * 11);
          chk($sformatf("str%0d_y1", got), oY_1, (got + 1) * 9);
          got++;
        end
      end else begin
        chk($sformatf("hold%0d_y0", c), oY_0, p0);
        chk($sformatf("hold%0d_y1", c), oY_1, p1);
        chk($sformatf("hold%0d_vld", c), oVALID, pv);
      end
    end
    iCE = 1'b1; iVALID = 1'b0;
    chk("str_count", got, 8);
    tick(); tick();

    // Reset with two beats in flight
    drive(v[0]); iVALID = 1'b1; tick();
    drive(v[2]); tick();
    iVALID = 1'b0;
    #2 iRESET = 1'b0;
    #1;
    chk("mrst_y0", oY_0, 0); chk("mrst_y1", oY_1, 0);
    chk("mrst_vld", oVALID, 0); chk("mrst_ovf", oOVF, 0);
    tick();
    iRESET = 1'b1;
    tick();
    chk("flush_vld0", oVALID, 0);
    tick();
    chk("flush_vld1", oVALID, 0);
    drive(v[3]); iVALID = 1'b1; tick();
    iVALID = 1'b0;
    chk("post_lat1_vld", oVALID, 0);
    tick();
    chk("post_lat2_vld", oVALID, 1);
    chk("post_y0", oY_0, 310);
    chk("post_y1", oY_1, -290);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
